// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit ALU adder among NREQ requesters, with a one-entry response buffer.
// Latency: a request accepted on edge N shows its result on rsp_* right after edge N; one add can be issued per cycle.
// Backpressure: grants stop while the buffer is FULL and rsp_ready is low; draining and accepting in the same cycle keeps full throughput.
module alu_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [16*NREQ-1:0]   req_x,
    input  logic [16*NREQ-1:0]   req_y,
    output logic [15:0]          alu_x,
    output logic [15:0]          alu_y,
    input  logic [15:0]          alu_z,
    input  logic [4:0]           alu_flags,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_z,
    output logic [4:0]           rsp_flags
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

    buf_state_t            state_q, state_d;
    logic [IDW-1:0]        ptr_q;
    logic [IDW-1:0]        gnt_id;
    logic [NREQ-1:0]       gnt_oh;
    logic                  gnt_found;
    logic                  can_issue;
    logic                  accept;
    int                    cand;

    // The buffer can take a new result when empty, or when its current one leaves this cycle.
    // rst_n gates issue so nothing is granted while the block is held in reset.
    assign can_issue = (state_q == EMPTY) || rsp_ready;
    assign accept    = gnt_found && can_issue && rst_n;
    assign rsp_valid = (state_q == FULL);

    // Search from ptr upward with an explicit wrap so non-power-of-two NREQ works.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_oh    = '0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand > NREQ - 1) begin
                cand = cand - NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_found && (i == cand) && req_valid[i]) begin
                    gnt_found = 1'b1;
                    gnt_id    = IDW'(i);
                    gnt_oh[i] = 1'b1;
                end
            end
        end
    end

    // Drive the winner's ready and operands; hold the ALU inputs at zero when nothing issues.
    always_comb begin
        req_ready = '0;
        alu_x     = '0;
        alu_y     = '0;
        if (accept) begin
            req_ready = gnt_oh;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_oh[i]) begin
                    alu_x = req_x[16*i +: 16];
                    alu_y = req_y[16*i +: 16];
                end
            end
        end
    end

    // Buffer occupancy: a new accept always leaves it FULL; a drain without accept empties it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (rsp_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Buffer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the ALU result with its requester tag and advance the pointer past the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_z     <= '0;
            rsp_flags <= '0;
            rsp_id    <= '0;
            ptr_q     <= '0;
        end else if (accept) begin
            rsp_z     <= alu_z;
            rsp_flags <= alu_flags;
            rsp_id    <= gnt_id;
            if (gnt_id == IDW'(NREQ - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= gnt_id + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed requests feed a scoreboard queue; a monitor pops on each consumed response.
// Latency: the bench ALU model is combinational, so results land on the accept edge.
// Backpressure: rsp_ready is driven by the stimulus to exercise stalls.
module tb_alu_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [16*NREQ-1:0]   req_x;
    logic [16*NREQ-1:0]   req_y;
    logic [15:0]          alu_x;
    logic [15:0]          alu_y;
    logic [15:0]          alu_z;
    logic [4:0]           alu_flags;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [15:0]          rsp_z;
    logic [4:0]           rsp_flags;

    alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_z     (alu_z),
        .alu_flags (alu_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_flags (rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: Z = X + Y, flags {Overflow, Parity(even), Carry, Zero, Sign}.
    logic [16:0] sum;
    assign sum       = {1'b0, alu_x} + {1'b0, alu_y};
    assign alu_z     = sum[15:0];
    assign alu_flags = {(alu_x[15] == alu_y[15]) && (sum[15] != alu_x[15]),
                        ~^sum[15:0], sum[16], sum[15:0] == 16'h0000, sum[15]};

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    z;
        logic [4:0]     f;
    } exp_t;

    exp_t            exp_q[$];
    int              nvec = 0;
    int              nerr = 0;
    logic [NREQ-1:0] acc;

    logic [15:0] rr_x [8];
    logic [15:0] rr_y [8];
    logic [15:0] rr_z [8];
    logic [4:0]  rr_f [8];
    int          rr_k [NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_rsp(input logic [IDW-1:0] id, input logic [15:0] z, input logic [4:0] f);
        exp_t e;
        e.id = id;
        e.z  = z;
        e.f  = f;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y);
        req_x[16*i +: 16] = x;
        req_y[16*i +: 16] = y;
    endtask

    // One clock: note accepts at the falling edge, retire them just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n;
        n = 0;
        while (req_valid != '0 && n < budget) begin
            cycle();
            n++;
        end
        chk(name, 32'(req_valid), 32'h0);
        req_valid = '0;
    endtask

    // Monitor: every response the consumer takes must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL rsp_unexpected: got id=%0d z=%h flags=%b, required no response",
                             rsp_id, rsp_z, rsp_flags);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_id !== e.id || rsp_z !== e.z || rsp_flags !== e.f) begin
                        nerr++;
                        $display("FAIL rsp_data: got id=%0d z=%h flags=%b, required id=%0d z=%h flags=%b",
                                 rsp_id, rsp_z, rsp_flags, e.id, e.z, e.f);
                    end
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int n;
        rr_x = '{16'h0001, 16'h1234, 16'h8000, 16'h00FF, 16'hFFFE, 16'h4000, 16'h0F0F, 16'hFFFF};
        rr_y = '{16'h0002, 16'h1111, 16'h8000, 16'h0001, 16'h0001, 16'h4000, 16'h0101, 16'hFFFF};
        rr_z = '{16'h0003, 16'h2345, 16'h0000, 16'h0100, 16'hFFFF, 16'h8000, 16'h1010, 16'hFFFE};
        rr_f = '{5'b01000, 5'b01000, 5'b11110, 5'b00000, 5'b01001, 5'b10001, 5'b01000, 5'b00101};
        for (int i = 0; i < NREQ; i++) rr_k[i] = 0;

        rst_n     = 1'b1;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b0;
        acc       = '0;
        #2 rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'b0001;
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_id",    32'(rsp_id),    32'h0);
        chk("reset_rsp_z",     32'(rsp_z),     32'h0);
        chk("reset_rsp_flags", 32'(rsp_flags), 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;

        // Single requester: signed overflow into the sign bit.
        set_req(0, 16'h7FFF, 16'h0001);
        expect_rsp(2'd0, 16'h8000, 5'b10001);
        req_valid = 4'b0001;
        run_until_idle("t1_accept_timeout", 10);

        // Wrap to zero with carry.
        set_req(2, 16'hFFFF, 16'h0001);
        expect_rsp(2'd2, 16'h0000, 5'b01110);
        req_valid = 4'b0100;
        run_until_idle("t2_accept_timeout", 10);

        // Grant to 3 moves the pointer to 0; idle cycles must not disturb it.
        set_req(3, 16'h0010, 16'h0020);
        expect_rsp(2'd3, 16'h0030, 5'b01000);
        req_valid = 4'b1000;
        run_until_idle("t5_grant3_timeout", 10);
        repeat (3) cycle();
        set_req(0, 16'h0005, 16'h0003);
        set_req(3, 16'h7000, 16'h1000);
        expect_rsp(2'd0, 16'h0008, 5'b00000);
        expect_rsp(2'd3, 16'h8000, 5'b10001);
        req_valid = 4'b1001;
        #1;
        chk("t5_first_grant", 32'(req_ready), 32'h1);
        run_until_idle("t5_accept_timeout", 10);

        // Round robin with all four requesters continuously valid.
        for (int i = 0; i < NREQ; i++) set_req(i, rr_x[i], rr_y[i]);
        for (int j = 0; j < 8; j++) expect_rsp(IDW'(j % NREQ), rr_z[j], rr_f[j]);
        req_valid = 4'b1111;
        #1;
        chk("rr_first_grant", 32'(req_ready), 32'h1);
        n = 0;
        while (req_valid != '0 && n < 20) begin
            cycle();
            chk("rr_one_accept_per_cycle", 32'($countones(acc)), 32'h1);
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    rr_k[i]++;
                    if (rr_k[i] < 2) begin
                        set_req(i, rr_x[NREQ + i], rr_y[NREQ + i]);
                        req_valid[i] = 1'b1;
                    end
                end
            end
            n++;
        end
        chk("rr_timeout", 32'(req_valid), 32'h0);
        repeat (2) cycle();

        // Back-pressure: fill the buffer, then stall with requesters 1 and 3 waiting.
        rsp_ready = 1'b0;
        set_req(0, 16'h0100, 16'h0200);
        expect_rsp(2'd0, 16'h0300, 5'b01000);
        req_valid = 4'b0001;
        run_until_idle("t4_fill_timeout", 10);
        set_req(1, 16'h0002, 16'h0002);
        set_req(3, 16'h8000, 16'h0001);
        expect_rsp(2'd1, 16'h0004, 5'b00000);
        expect_rsp(2'd3, 16'h8001, 5'b01001);
        req_valid = 4'b1010;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_req_ready",  32'(req_ready), 32'h0);
            chk("bp_rsp_valid",  32'(rsp_valid), 32'h1);
            chk("bp_rsp_z_hold", 32'(rsp_z),     32'h0300);
            cycle();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'h2);
        run_until_idle("t4_drain_timeout", 10);
        repeat (2) cycle();

        // Asynchronous reset while FULL with the pointer at 2.
        rsp_ready = 1'b0;
        set_req(1, 16'h1111, 16'h2222);
        req_valid = 4'b0010;
        run_until_idle("t6_fill_timeout", 10);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_rsp_valid", 32'(rsp_valid), 32'h0);
        set_req(1, 16'h0003, 16'h0004);
        set_req(2, 16'h7FFF, 16'h7FFF);
        expect_rsp(2'd1, 16'h0007, 5'b00000);
        expect_rsp(2'd2, 16'hFFFE, 5'b10001);
        req_valid = 4'b0110;
        #1;
        chk("rst_req_ready_low", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("rst_first_grant", 32'(req_ready), 32'h2);
        run_until_idle("t6_accept_timeout", 10);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
